capacity_tracker: RTL and testbench



---
 rtl/capacity_tracker.sv | 102 ++++++++++
 tb/tb_capacity_tracker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/capacity_tracker.sv
// Multi-channel occupancy tracker: per-channel counts driven by arrive/depart/load,
// bounded by a shared cap_max, with full/empty status, sticky error flags and a registered total.
module capacity_tracker #(
  parameter int WIDTH      = 4,
  parameter int CHANNELS   = 4,
  parameter bit CLAMP_MODE = 1'b1,
  parameter int TOTAL_W    = WIDTH + $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [WIDTH-1:0]          cap_max,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] cap_des,
  input  logic [CHANNELS-1:0]       arrive,
  input  logic [CHANNELS-1:0]       depart,
  input  logic                      clr_err,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       full,
  output logic [CHANNELS-1:0]       empty,
  output logic [CHANNELS-1:0]       reject,
  output logic [CHANNELS-1:0]       underflow,
  output logic [TOTAL_W-1:0]        total
);

  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic [WIDTH-1:0]    des   [CHANNELS];
  logic [CHANNELS-1:0] rej_set;
  logic [CHANNELS-1:0] und_set;
  logic [TOTAL_W-1:0]  sum;

  // Per-channel next-count selection; load outranks simultaneous arrive/depart.
  always_comb begin
    rej_set = '0;
    und_set = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      des[i]   = cap_des[i*WIDTH +: WIDTH];
      cnt_d[i] = cnt_q[i];
      if (en) begin
        if (load[i]) begin
          if (des[i] <= cap_max) begin
            cnt_d[i] = des[i];
          end else if (cnt_q[i] > cap_max) begin
            cnt_d[i] = cap_max;
          end
        end else if (arrive[i] && depart[i]) begin
          cnt_d[i] = cnt_q[i];
        end else if (arrive[i]) begin
          if (cnt_q[i] < cap_max) begin
            cnt_d[i] = cnt_q[i] + WIDTH'(1);
          end else begin
            rej_set[i] = 1'b1;
          end
        end else if (depart[i]) begin
          if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - WIDTH'(1);
          end else begin
            und_set[i] = 1'b1;
          end
        end
        // Post-clamp also catches a cap_max that dropped below a held count.
        if (CLAMP_MODE && (cnt_d[i] > cap_max)) begin
          cnt_d[i] = cap_max;
        end
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sum = sum + TOTAL_W'(cnt_q[i]);
    end
  end

  // A flag raised in the same cycle as clr_err survives the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      reject    <= '0;
      underflow <= '0;
      total     <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      reject    <= clr_err ? rej_set : (reject | rej_set);
      underflow <= clr_err ? und_set : (underflow | und_set);
      total     <= sum;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign count[g*WIDTH +: WIDTH] = cnt_q[g];
    assign full[g]  = (cnt_q[g] >= cap_max);
    assign empty[g] = (cnt_q[g] == '0);
  end

endmodule

// File: tb/tb_capacity_tracker.sv
// Bench for capacity_tracker: one clamping and one holding instance share the same randomized
// stimulus; a reference model feeds expected-value queues that a monitor drains every cycle.
module tb_capacity_tracker;
  localparam int W  = 4;
  localparam int CH = 4;
  localparam int TW = W + $clog2(CH);

  typedef struct packed {
    logic [CH*W-1:0] count;
    logic [CH-1:0]   full;
    logic [CH-1:0]   empty;
    logic [CH-1:0]   reject;
    logic [CH-1:0]   underflow;
    logic [TW-1:0]   total;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [W-1:0]  cap_max = '0;
  logic [CH-1:0] load = '0;
  logic [CH*W-1:0] cap_des = '0;
  logic [CH-1:0] arrive = '0;
  logic [CH-1:0] depart = '0;
  logic          clr_err = 1'b0;

  exp_t act_c, act_h;
  logic [CH*W-1:0] count_c, count_h;
  logic [CH-1:0]   full_c, full_h, empty_c, empty_h, reject_c, reject_h, underflow_c, underflow_h;
  logic [TW-1:0]   total_c, total_h;

  capacity_tracker #(.WIDTH(W), .CHANNELS(CH), .CLAMP_MODE(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .cap_max(cap_max), .load(load), .cap_des(cap_des),
    .arrive(arrive), .depart(depart), .clr_err(clr_err), .count(count_c), .full(full_c),
    .empty(empty_c), .reject(reject_c), .underflow(underflow_c), .total(total_c));

  capacity_tracker #(.WIDTH(W), .CHANNELS(CH), .CLAMP_MODE(1'b0)) dut_h (
    .clk(clk), .rst_n(rst_n), .en(en), .cap_max(cap_max), .load(load), .cap_des(cap_des),
    .arrive(arrive), .depart(depart), .clr_err(clr_err), .count(count_h), .full(full_h),
    .empty(empty_h), .reject(reject_h), .underflow(underflow_h), .total(total_h));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Index 0 models the clamping instance, index 1 the holding instance.
  int m_cnt [2][CH];
  bit m_rej [2][CH];
  bit m_und [2][CH];
  int m_tot [2];

  exp_t exp_c_q[$];
  exp_t exp_h_q[$];

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  function automatic exp_t snapshot(int d);
    exp_t e;
    e = '0;
    for (int i = 0; i < CH; i++) begin
      e.count[i*W +: W] = W'(m_cnt[d][i]);
      e.full[i]         = (m_cnt[d][i] >= int'(cap_max));
      e.empty[i]        = (m_cnt[d][i] == 0);
      e.reject[i]       = m_rej[d][i];
      e.underflow[i]    = m_und[d][i];
    end
    e.total = TW'(m_tot[d]);
    return e;
  endfunction

  task automatic model_step();
    int cap, c, n, ds;
    bit rs, us;
    cap = int'(cap_max);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        for (int i = 0; i < CH; i++) begin
          m_cnt[d][i] = 0; m_rej[d][i] = 0; m_und[d][i] = 0;
        end
        m_tot[d] = 0;
      end else begin
        m_tot[d] = 0;
        for (int i = 0; i < CH; i++) m_tot[d] += m_cnt[d][i];
        for (int i = 0; i < CH; i++) begin
          c = m_cnt[d][i]; n = c; rs = 0; us = 0;
          ds = int'(cap_des[i*W +: W]);
          if (en) begin
            if (load[i])                   n = (ds <= cap) ? ds : ((c > cap) ? cap : c);
            else if (arrive[i] && depart[i]) n = c;
            else if (arrive[i])            begin if (c < cap) n = c + 1; else rs = 1; end
            else if (depart[i])            begin if (c > 0) n = c - 1; else us = 1; end
            if (d == 0 && n > cap) n = cap;
          end
          m_cnt[d][i] = n;
          m_rej[d][i] = clr_err ? rs : (m_rej[d][i] | rs);
          m_und[d][i] = clr_err ? us : (m_und[d][i] | us);
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit r, input bit e, input int cap, input logic [CH-1:0] ld,
                       input logic [CH*W-1:0] ds, input logic [CH-1:0] ar,
                       input logic [CH-1:0] dp, input bit clr);
    @(negedge clk);
    rst_n = r; en = e; cap_max = W'(cap); load = ld; cap_des = ds;
    arrive = ar; depart = dp; clr_err = clr;
    model_step();
    exp_c_q.push_back(snapshot(0));
    exp_h_q.push_back(snapshot(1));
  endtask

  task automatic idle(input int cap, input int n);
    for (int k = 0; k < n; k++) drive(1, 1, cap, '0, '0, '0, '0, 0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic compare(input string tag, input exp_t a, input exp_t e);
    check({tag, ".count"},     64'(a.count),     64'(e.count));
    check({tag, ".full"},      64'(a.full),      64'(e.full));
    check({tag, ".empty"},     64'(a.empty),     64'(e.empty));
    check({tag, ".reject"},    64'(a.reject),    64'(e.reject));
    check({tag, ".underflow"}, 64'(a.underflow), 64'(e.underflow));
    check({tag, ".total"},     64'(a.total),     64'(e.total));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      act_c = '{count_c, full_c, empty_c, reject_c, underflow_c, total_c};
      act_h = '{count_h, full_h, empty_h, reject_h, underflow_h, total_h};
      if (exp_c_q.size() > 0) compare("clamp", act_c, exp_c_q.pop_front());
      if (exp_h_q.size() > 0) compare("hold",  act_h, exp_h_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [CH-1:0] ld, ar, dp;
    int cap, wait_cyc;
    // 1: reset with arrivals pending
    drive(0, 1, 3, '0, '0, '1, '0, 0);
    drive(0, 1, 3, '0, '0, '1, '0, 0);
    // 2: fill channel 0 past cap_max=3, then clear the reject
    for (int k = 0; k < 5; k++) drive(1, 1, 3, '0, '0, 4'b0001, '0, 0);
    drive(1, 1, 3, '0, '0, '0, '0, 1);
    // 3: load rule on channel 0
    drive(1, 1, 8, 4'b0001, 16'h0005, '0, '0, 0);
    drive(1, 1, 8, 4'b0001, 16'h0007, '0, '0, 0);
    drive(1, 1, 8, 4'b0001, 16'h000C, 4'b0001, 4'b0001, 0);
    drive(1, 1, 4, 4'b0001, 16'h000C, '0, '0, 0);
    // 4: cap_max drops under a loaded count; holding instance rejects and drains
    drive(1, 1, 8, 4'b0001, 16'h0006, '0, '0, 0);
    idle(2, 1);
    drive(1, 1, 2, '0, '0, 4'b0001, '0, 0);
    for (int k = 0; k < 4; k++) drive(1, 1, 2, '0, '0, '0, 4'b0001, 0);
    // 5: simultaneous events at the top, departures at zero with and without clr_err
    drive(1, 1, 3, 4'b0010, 16'h0030, '0, '0, 1);
    drive(1, 1, 3, '0, '0, 4'b0010, 4'b0010, 0);
    drive(1, 1, 3, '0, '0, '0, 4'b0100, 0);
    drive(1, 1, 3, '0, '0, '0, 4'b0100, 1);
    drive(1, 1, 0, '0, '0, 4'b1111, '0, 0);
    // 6: counts 3,2,0,5 then total, then en=0 with arrivals pending
    drive(1, 1, 8, 4'b1111, 16'h5023, '0, '0, 1);
    idle(8, 2);
    drive(1, 0, 8, 4'b1111, 16'h1111, 4'b1111, '0, 0);
    drive(1, 0, 8, '0, '0, 4'b1111, 4'b1111, 0);
    drive(1, 0, 8, '0, '0, 4'b1111, '0, 1);
    // randomized phase
    cap = 8;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 9) == 0) cap = $urandom_range(0, 15);
      ld = '0;
      for (int i = 0; i < CH; i++) ld[i] = ($urandom_range(0, 7) == 0);
      ar = CH'($urandom);
      dp = CH'($urandom);
      drive(($urandom_range(0, 149) != 0), ($urandom_range(0, 9) != 0), cap, ld,
            (CH*W)'($urandom), ar, dp, ($urandom_range(0, 7) == 0));
    end
    idle(cap, 2);
    wait_cyc = 0;
    while ((exp_c_q.size() > 0 || exp_h_q.size() > 0) && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    checks++;
    if (exp_c_q.size() == 0 && exp_h_q.size() == 0) passes++;
    else $display("FAIL drain: got %0d pending expected 0", exp_c_q.size() + exp_h_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
